// File: rtl/alu_seq.sv
// alu_seq: registers ALU requests, captures results a cycle later and returns them tagged through a response FIFO
module alu_seq #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  output logic [3:0]       alu_control,
  input  logic [31:0]      alu_out,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      done_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;
  logic [0:0]       state;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      mem_data [DEPTH];
  logic             mem_zero [DEPTH];
  logic             mem_neg  [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             accept, push, pop;
  // space is only checked at acceptance; one op in flight means the push never overflows
  assign req_ready = !rst && state == IDLE && count < FULL;
  assign accept    = req_valid && req_ready;
  assign push      = state == EXEC;
  assign rsp_valid = count != '0;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
  assign rsp_zero  = rsp_valid ? mem_zero[rd_ptr] : 1'b0;
  assign rsp_neg   = rsp_valid ? mem_neg[rd_ptr]  : 1'b0;
  assign rsp_tag   = rsp_valid ? mem_tag[rd_ptr]  : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_control <= '0;
      tag_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      done_count  <= '0;
    end else begin
      state <= accept ? EXEC : IDLE;
      if (accept) begin
        alu_in1     <= req_a;
        alu_in2     <= req_b;
        alu_control <= req_op;
        tag_q       <= req_tag;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        done_count <= done_count + 16'd1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= alu_out;
      mem_zero[wr_ptr] <= alu_zero;
      mem_neg[wr_ptr]  <= alu_neg;
      mem_tag[wr_ptr]  <= tag_q;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table plus hand sequences, scoreboarded against a behavioural ALU stand-in
module tb_alu_seq;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready;
  logic [3:0]  req_op = 0;
  logic [31:0] req_a = 0, req_b = 0;
  logic [3:0]  req_tag = 0;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_control;
  logic        alu_zero, alu_neg;
  logic        rsp_valid, rsp_ready = 0, rsp_zero, rsp_neg;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic [15:0] done_count;

  typedef struct {logic [3:0] op; logic [31:0] a, b; logic [3:0] tag; logic [31:0] d; logic z, n;} vec_t;
  typedef struct {logic [31:0] d; logic z, n; logic [3:0] tag;} rsp_t;
  rsp_t sb[$];
  rsp_t cur;
  vec_t vecs[6];
  int checks = 0, errors = 0;
  bit stream = 0;

  alu_seq #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_control(alu_control), .alu_out(alu_out), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_neg(rsp_neg), .rsp_tag(rsp_tag), .done_count(done_count)
  );

  always #5 clk = ~clk;

  assign alu_out  = alu_control == 4'b0000 ? alu_in1 + alu_in2 :
                    alu_control == 4'b0001 ? alu_in1 - alu_in2 : 32'd0;
  assign alu_zero = alu_out == 32'd0;
  assign alu_neg  = alu_out[31];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got tag %h expected none", rsp_tag);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
        chk("rsp_neg", 32'(rsp_neg), 32'(e.n));
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      end
    end
    if (req_valid && req_ready) sb.push_back(cur);
    if (stream) chk("in_flight_le1", 32'(sb.size() <= 1), 32'd1);
  end

  task automatic send(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] tag,
                      logic [31:0] d, logic z, logic n);
    bit ok = 0;
    cur = '{d, z, n, tag};
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got no req_ready expected accept of tag %h", tag);
    end
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{4'b0001, 32'd5, 32'd7, 4'd1, 32'hFFFFFFFE, 1'b0, 1'b1};
    vecs[1] = '{4'b0001, 32'd9, 32'd9, 4'd2, 32'd0, 1'b1, 1'b0};
    vecs[2] = '{4'b0000, 32'hFFFFFFFF, 32'd1, 4'd5, 32'd0, 1'b1, 1'b0};
    vecs[3] = '{4'b0001, 32'd0, 32'd1, 4'd6, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[4] = '{4'b0000, 32'h12345678, 32'h11111111, 4'd7, 32'h23456789, 1'b0, 1'b0};
    vecs[5] = '{4'b1111, 32'd3, 32'd4, 4'd8, 32'd0, 1'b1, 1'b0};
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_control", 32'(alu_control), 32'd0);
    chk("rst_done_count", 32'(done_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    send(4'b0000, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 1'b0);
    chk("alu_in2_latched", alu_in2, 32'd7);
    @(posedge clk); #1;
    chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lat_rsp_data", rsp_data, 32'd12);
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("done_count_1", 32'(done_count), 32'd1);
    foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].d, vecs[i].z, vecs[i].n);
    drain();
    chk("done_count_7", 32'(done_count), 32'd7);
    rsp_ready = 0;
    for (int i = 0; i < 4; i++) send(4'b0000, 32'(i + 1), 32'd10, 4'(i), 32'(i + 11), 1'b0, 1'b0);
    fork
      send(4'b0000, 32'd5, 32'd10, 4'd4, 32'd15, 1'b0, 1'b0);
    join_none
    repeat (3) begin
      @(negedge clk);
      chk("full_req_ready", 32'(req_ready), 32'd0);
      chk("full_head_tag", 32'(rsp_tag), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    wait fork;
    drain();
    stream = 1;
    for (int i = 0; i < 4; i++) send(4'b0101, 32'(i * 3 + 1), 32'd2, 4'(i + 9), 32'd0, 1'b1, 1'b0);
    drain();
    stream = 0;
    send(4'b0000, 32'd1, 32'd2, 4'd13, 32'd3, 1'b0, 1'b0);
    rst = 1;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_done_count", 32'(done_count), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("dropped_no_rsp", 32'(rsp_valid), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
